// File: rtl/feed_ab.sv
// feed_ab: head-of-chain feeder for the A/B operand FIFO chains.
// Streams one K-deep tile from a fixed-latency read memory into FIFO A and FIFO B.
module feed_ab #(
   parameter int D_WIDTH     = 64,
   parameter int A_NUM_WIDTH = 1,
   parameter int B_NUM_WIDTH = 1,
   parameter int K_WIDTH     = 8,
   parameter int ADDR_W      = 32,
   parameter int RD_LAT      = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_A,
   input  logic [ADDR_W-1:0]  base_B,
   input  logic [K_WIDTH-1:0] k_len,
   output logic               busy,
   output logic               done,
   output logic               mem_re,
   output logic [ADDR_W-1:0]  mem_raddr,
   input  logic [D_WIDTH-1:0] mem_rdata,
   output logic               fifo_A_wr_en,
   output logic [D_WIDTH-1:0] fifo_A_data,
   input  logic               fifo_A_almost_full,
   output logic               fifo_B_wr_en,
   output logic [D_WIDTH-1:0] fifo_B_data,
   input  logic               fifo_B_almost_full
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, DRAIN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      ptr_a_q, ptr_a_d;
   logic [ADDR_W-1:0]      ptr_b_q, ptr_b_d;
   logic [K_WIDTH-1:0]     k_rem_q, k_rem_d;
   logic [A_NUM_WIDTH-1:0] cnt_a_q, cnt_a_d;
   logic [B_NUM_WIDTH-1:0] cnt_b_q, cnt_b_d;
   logic                   issue, dest;
   logic [RD_LAT-1:0]      tag_v_q, tag_d_q;
   logic                   a_wr_q, b_wr_q;
   logic [D_WIDTH-1:0]     a_data_q, b_data_q;

   always_comb begin
      state_d   = state_q;
      ptr_a_d   = ptr_a_q;
      ptr_b_d   = ptr_b_q;
      k_rem_d   = k_rem_q;
      cnt_a_d   = cnt_a_q;
      cnt_b_d   = cnt_b_q;
      issue     = 1'b0;
      dest      = 1'b0;
      mem_raddr = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ptr_a_d = base_A;
               ptr_b_d = base_B;
               k_rem_d = k_len;
               state_d = (k_len == '0) ? DONE : RD_A;
            end
         end
         RD_A: begin
            if (!fifo_A_almost_full) begin
               issue     = 1'b1;
               mem_raddr = ptr_a_q;
               ptr_a_d   = ptr_a_q + ADDR_W'(1);
               cnt_a_d   = cnt_a_q + A_NUM_WIDTH'(1);
               if (cnt_a_q == '1) state_d = RD_B;
            end
         end
         RD_B: begin
            if (!fifo_B_almost_full) begin
               issue     = 1'b1;
               dest      = 1'b1;
               mem_raddr = ptr_b_q;
               ptr_b_d   = ptr_b_q + ADDR_W'(1);
               cnt_b_d   = cnt_b_q + B_NUM_WIDTH'(1);
               if (cnt_b_q == '1) begin
                  k_rem_d = k_rem_q - K_WIDTH'(1);
                  state_d = (k_rem_q == K_WIDTH'(1)) ? DRAIN : RD_A;
               end
            end
         end
         DRAIN: begin
            if (tag_v_q == '0) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_a_q <= '0;
         ptr_b_q <= '0;
         k_rem_q <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_a_q <= ptr_a_d;
         ptr_b_q <= ptr_b_d;
         k_rem_q <= k_rem_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   // Tag pipe tracks {valid, dest} in lockstep with the memory latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_q  <= '0;
         tag_d_q  <= '0;
         a_wr_q   <= 1'b0;
         b_wr_q   <= 1'b0;
         a_data_q <= '0;
         b_data_q <= '0;
      end else begin
         tag_v_q[0] <= issue;
         tag_d_q[0] <= dest;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_d_q[i] <= tag_d_q[i-1];
         end
         a_wr_q <= tag_v_q[RD_LAT-1] & ~tag_d_q[RD_LAT-1];
         b_wr_q <= tag_v_q[RD_LAT-1] &  tag_d_q[RD_LAT-1];
         if (tag_v_q[RD_LAT-1] && !tag_d_q[RD_LAT-1]) a_data_q <= mem_rdata;
         if (tag_v_q[RD_LAT-1] &&  tag_d_q[RD_LAT-1]) b_data_q <= mem_rdata;
      end
   end

   assign mem_re       = issue;
   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign fifo_A_wr_en = a_wr_q;
   assign fifo_A_data  = a_data_q;
   assign fifo_B_wr_en = b_wr_q;
   assign fifo_B_data  = b_data_q;

endmodule
